// File: rtl/lanectrl_pause_pkg.sv
// Shared types and limits for the HS_IO clock-pause conditioner.
// Lane FSM encoding, counter width and legal parameter ranges.
package lanectrl_pause_pkg;

    localparam int unsigned CNT_W = 4;

    localparam int unsigned MIN_LANES      = 1;
    localparam int unsigned MAX_LANES      = 16;
    localparam int unsigned MIN_SYNC       = 1;
    localparam int unsigned MAX_SYNC       = 4;
    localparam int unsigned MIN_PAUSE_LIM  = 1;
    localparam int unsigned MAX_PAUSE_LIM  = 15;
    localparam int unsigned MAX_GAP_LIM    = 15;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPause = 2'd1,
        StGap   = 2'd2
    } lane_state_e;

endpackage

// File: rtl/lanectrl_pause_ctrl_if.sv
// Per-lane pause request/enable inputs and conditioned pause outputs.
// The conditioner uses the slave modport; the request source uses master.
interface lanectrl_pause_ctrl_if #(
    parameter int unsigned NUM_LANES = 4
) ();
    logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE;
    logic [NUM_LANES-1:0] LANE_ENABLE;
    logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC;
    logic                 PAUSE_ACTIVE;
    logic [NUM_LANES-1:0] PAUSE_DEFERRED;

    modport master (
        output HS_IO_CLK_PAUSE,
        output LANE_ENABLE,
        input  HS_IO_CLK_PAUSE_SYNC,
        input  PAUSE_ACTIVE,
        input  PAUSE_DEFERRED
    );

    modport slave (
        input  HS_IO_CLK_PAUSE,
        input  LANE_ENABLE,
        output HS_IO_CLK_PAUSE_SYNC,
        output PAUSE_ACTIVE,
        output PAUSE_DEFERRED
    );
endinterface

// File: rtl/lanectrl_pause_lane.sv
// One lane: request synchroniser, IDLE/PAUSE/GAP stretcher with deferred
// re-pause, and an optional falling-edge retiming flop on the output.
module lanectrl_pause_lane
    import lanectrl_pause_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned MIN_PAUSE_CYCLES = 2,
    parameter int unsigned MIN_GAP_CYCLES   = 1,
    parameter bit          FALL_EDGE_OUT    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic en_i,
    output logic pause_d_o,
    output logic pause_o,
    output logic deferred_o
);
    localparam logic [CNT_W-1:0] PauseLast = CNT_W'(MIN_PAUSE_CYCLES - 1);
    localparam int unsigned      GapLastI  = (MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GapLastI);

    (* async_reg = "true", keep = "true" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   req_s;

    lane_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             pause_q, pause_d;
    logic             defer_q, defer_d;

    always_comb begin
        sync_d[0] = req_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        defer_d = 1'b0;
        if (!en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_s) begin
                        state_d = StPause;
                        cnt_d   = '0;
                    end
                end
                StPause: begin
                    // Counter saturates at the last minimum-width cycle.
                    if (cnt_q != PauseLast) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (!req_s) begin
                        cnt_d   = '0;
                        state_d = (MIN_GAP_CYCLES > 0) ? StGap : StIdle;
                    end
                end
                StGap: begin
                    cnt_d = cnt_q + 1'b1;
                    if (req_s && !pend_q) begin
                        pend_d  = 1'b1;
                        defer_d = 1'b1;
                    end
                    if (cnt_q == GapLast) begin
                        cnt_d = '0;
                        if (pend_q || req_s) begin
                            pend_d  = 1'b0;
                            state_d = StPause;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        pause_d = (state_d == StPause);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pause_q <= 1'b0;
            defer_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pause_q <= pause_d;
            defer_q <= defer_d;
        end
    end

    if (FALL_EDGE_OUT) begin : g_fall
        logic fall_q;
        // Reset stays asynchronous so the output drops without waiting for an edge.
        always_ff @(negedge clk_i or posedge rst_i) begin
            if (rst_i) fall_q <= 1'b0;
            else       fall_q <= pause_q;
        end
        assign pause_o = fall_q;
    end else begin : g_rise
        assign pause_o = pause_q;
    end

    assign pause_d_o  = pause_d;
    assign deferred_o = defer_q;

endmodule

// File: rtl/lanectrl_pause_ctrl.sv
// Multi-lane HS_IO clock-pause conditioner: independent per-lane stretchers
// plus a registered any-lane-paused flag.
module lanectrl_pause_ctrl
    import lanectrl_pause_pkg::*;
#(
    parameter int unsigned NUM_LANES        = 4,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned MIN_PAUSE_CYCLES = 2,
    parameter int unsigned MIN_GAP_CYCLES   = 1,
    parameter bit          FALL_EDGE_OUT    = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    lanectrl_pause_ctrl_if.slave bus
);
    if (NUM_LANES < MIN_LANES || NUM_LANES > MAX_LANES) begin : g_bad_lanes
        $error("NUM_LANES out of range");
    end
    if (SYNC_STAGES < MIN_SYNC || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end
    if (MIN_PAUSE_CYCLES < MIN_PAUSE_LIM || MIN_PAUSE_CYCLES > MAX_PAUSE_LIM) begin : g_bad_pause
        $error("MIN_PAUSE_CYCLES out of range");
    end
    if (MIN_GAP_CYCLES > MAX_GAP_LIM) begin : g_bad_gap
        $error("MIN_GAP_CYCLES out of range");
    end

    logic [NUM_LANES-1:0] pause_d;
    logic [NUM_LANES-1:0] pause_out;
    logic [NUM_LANES-1:0] deferred;
    logic                 active_q, active_d;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lanectrl_pause_lane #(
            .SYNC_STAGES     (SYNC_STAGES),
            .MIN_PAUSE_CYCLES(MIN_PAUSE_CYCLES),
            .MIN_GAP_CYCLES  (MIN_GAP_CYCLES),
            .FALL_EDGE_OUT   (FALL_EDGE_OUT)
        ) u_lane (
            .clk_i     (CLK),
            .rst_i     (RESET),
            .req_i     (bus.HS_IO_CLK_PAUSE[g]),
            .en_i      (bus.LANE_ENABLE[g]),
            .pause_d_o (pause_d[g]),
            .pause_o   (pause_out[g]),
            .deferred_o(deferred[g])
        );
    end

    // Built from next-state so the flag moves on the same edge as each pause bit.
    always_comb active_d = |pause_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) active_q <= 1'b0;
        else       active_q <= active_d;
    end

    assign bus.HS_IO_CLK_PAUSE_SYNC = pause_out;
    assign bus.PAUSE_ACTIVE         = active_q;
    assign bus.PAUSE_DEFERRED       = deferred;

endmodule
